// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and defaults for the edge_event_arbiter block.
package edge_event_arbiter_pkg;

   // Default channel count
   localparam int unsigned N_DEFAULT = 4;

   // Per-channel detect mode
   typedef enum logic {
      DET_RISE  = 1'b0,
      DET_PULSE = 1'b1
   } det_mode_e;

   // Output register occupancy
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage : edge_event_arbiter_pkg

// File: rtl/edge_event_arbiter_event_detector.sv
// One channel of edge/pulse detection: two history flops plus the mode mux.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   a         - level input, already synchronous to clk
//   mode      - 0 = rising edge, 1 = one-cycle 010 pulse
//   det_c     - combinational detect strobe
module event_detector
   import edge_event_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic mode,
   output logic det_c
);

   logic a_r;
   logic a_r2;

   // History shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r  <= 1'b0;
         a_r2 <= 1'b0;
      end else begin
         a_r  <= a;
         a_r2 <= a_r;
      end
   end

   // Pulse mode waits for the trailing 0, so it fires one cycle after rising mode would
   always_comb begin
      det_c = 1'b0;
      if (det_mode_e'(mode) == DET_PULSE) begin
         det_c = ~a_r2 & a_r & ~a;
      end else begin
         det_c = ~a_r & a;
      end
   end

endmodule : event_detector

// File: rtl/edge_event_arbiter.sv
// Multi-channel event front-end: per-channel edge/pulse detection latched as
// pending requests, serialised by a round-robin arbiter into one valid/ready stream.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   a[N]          - level inputs
//   cfg_mode[N]   - per-channel detect mode (static outside reset)
//   out_valid     - event available
//   out_id        - channel index of the event
//   out_ready     - consumer accepts
//   pending[N]    - latched, not-yet-issued requests
//   overflow[N]   - sticky dropped-event flags
//   clr_overflow  - clears overflow on the next edge (a same-cycle set wins)
module edge_event_arbiter
   import edge_event_arbiter_pkg::*;
#(
   parameter int unsigned N    = N_DEFAULT,
   parameter int unsigned ID_W = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    cfg_mode,
   output logic            out_valid,
   output logic [ID_W-1:0] out_id,
   input  logic            out_ready,
   output logic [N-1:0]    pending,
   output logic [N-1:0]    overflow,
   input  logic            clr_overflow
);

   out_state_e      state;
   out_state_e      state_nxt;
   logic [N-1:0]    det_c;
   logic [N-1:0]    take_c;
   logic            hs_c;
   logic            load_c;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] ptr_nxt_c;
   logic [ID_W-1:0] grant_id_c;
   logic            grant_found_c;
   logic [ID_W:0]   scan_sum_c;
   logic [ID_W-1:0] scan_idx_c;

   // Per-channel detectors
   for (genvar i = 0; i < N; i++) begin : g_det
      event_detector u_det (
         .clk   (clk),
         .rst   (rst),
         .a     (a[i]),
         .mode  (cfg_mode[i]),
         .det_c (det_c[i])
      );
   end

   // Round-robin scan of start-of-cycle pending, from ptr upward with wrap
   always_comb begin
      grant_found_c = 1'b0;
      grant_id_c    = '0;
      scan_sum_c    = '0;
      scan_idx_c    = '0;
      for (int k = 0; k < int'(N); k++) begin
         scan_sum_c = {1'b0, ptr} + (ID_W+1)'(k);
         if (scan_sum_c >= (ID_W+1)'(N)) begin
            scan_sum_c = scan_sum_c - (ID_W+1)'(N);
         end
         scan_idx_c = ID_W'(scan_sum_c);
         if (!grant_found_c && pending[scan_idx_c]) begin
            grant_found_c = 1'b1;
            grant_id_c    = scan_idx_c;
         end
      end
   end

   // Pointer advances past the granted channel
   always_comb begin
      ptr_nxt_c = grant_id_c + ID_W'(1);
      if (grant_id_c == ID_W'(N - 1)) begin
         ptr_nxt_c = '0;
      end
   end

   // Output register FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Output register FSM: next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         OUT_EMPTY: if (load_c) state_nxt = OUT_FULL;
         OUT_FULL:  if (hs_c && !load_c) state_nxt = OUT_EMPTY;
         default:   state_nxt = OUT_EMPTY;
      endcase
   end

   // Output register FSM: handshake, load and take strobes
   always_comb begin
      hs_c   = 1'b0;
      load_c = 1'b0;
      take_c = '0;
      hs_c   = (state == OUT_FULL) && out_ready;
      load_c = ((state == OUT_EMPTY) || hs_c) && grant_found_c;
      if (load_c) begin
         take_c = N'(1) << grant_id_c;
      end
   end

   assign out_valid = (state == OUT_FULL);

   // Pending, overflow, output id and pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         overflow <= '0;
         out_id   <= '0;
         ptr      <= '0;
      end else begin
         pending  <= (pending & ~take_c) | det_c;
         // A detect on a still-pending channel merges and is flagged; set beats clear
         overflow <= (clr_overflow ? '0 : overflow) | (det_c & pending & ~take_c);
         if (load_c) begin
            out_id <= grant_id_c;
            ptr    <= ptr_nxt_c;
         end
      end
   end

endmodule : edge_event_arbiter

// File: tb/tb_edge_event_arbiter.sv
// Directed, table-driven bench for edge_event_arbiter (N = 4).
module tb_edge_event_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic [3:0] cfg_mode;
   logic       out_valid;
   logic [1:0] out_id;
   logic       out_ready;
   logic [3:0] pending;
   logic [3:0] overflow;
   logic       clr_overflow;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic [3:0] a;
      logic [3:0] mode;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [1:0] eid;
      logic [3:0] ep;
      logic [3:0] eo;
   } vec_t;

   vec_t tv[$];

   edge_event_arbiter #(.N(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .a            (a),
      .cfg_mode     (cfg_mode),
      .out_valid    (out_valid),
      .out_id       (out_id),
      .out_ready    (out_ready),
      .pending      (pending),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int row, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h want %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] av, input logic [3:0] m,
                      input logic rd, input logic c, input logic v, input logic [1:0] id,
                      input logic [3:0] p, input logic [3:0] o);
      vec_t t;
      t.rst = r; t.a = av; t.mode = m; t.rdy = rd; t.clr = c;
      t.ev = v; t.eid = id; t.ep = p; t.eo = o;
      tv.push_back(t);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit seen;
      rst = 1'b1; a = '0; cfg_mode = '0; out_ready = 1'b1; clr_overflow = 1'b0;

      // rst a mode rdy clr | valid id pending overflow
      // single rising edge on ch2
      add(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0100, 4'b0000);
      add(0, 4'b0100, 4'b0000, 1, 0, 1, 2, 4'b0000, 4'b0000);
      add(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      // all four rise together from ptr=0
      add(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 4'b1110, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 1, 4'b1100, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 2, 4'b1000, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 3, 4'b0000, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      // one ch0 event moves ptr to 1, then all four again
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0001, 4'b0000, 1, 0, 0, 0, 4'b0001, 4'b0000);
      add(0, 4'b0001, 4'b0000, 1, 0, 1, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b1111, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 1, 4'b1101, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 2, 4'b1001, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 3, 4'b0001, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 1, 0, 4'b0000, 4'b0000);
      add(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      // backpressure: repeated ch0 rises, overflow, release, clear
      add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0000);
      add(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000);
      add(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000);
      add(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0000);
      add(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0001);
      add(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0001, 4'b0001);
      add(0, 4'b0001, 4'b0000, 1, 0, 1, 0, 4'b0000, 4'b0001);
      add(0, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      // ch3 taken in the same cycle a new ch3 edge is detected
      add(0, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0000);
      add(0, 4'b1000, 4'b0000, 0, 0, 1, 0, 4'b1000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'b1000, 4'b0000);
      add(0, 4'b1000, 4'b0000, 1, 0, 1, 3, 4'b1000, 4'b0000);
      add(0, 4'b1000, 4'b0000, 1, 0, 1, 3, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      // reset mid-stream with valid=1 and pending=1010
      add(0, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b0000);
      add(0, 4'b1010, 4'b0000, 0, 0, 1, 0, 4'b1010, 4'b0000);
      add(1, 4'b1010, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      // input already high as reset deasserts
      add(1, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0100, 4'b0000);
      add(0, 4'b0100, 4'b0000, 1, 0, 1, 2, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000);
      // pulse mode on ch1: 010 fires, 0110 does not
      add(1, 4'b0000, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0010, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 4'b0010, 4'b0000);
      add(0, 4'b0000, 4'b0010, 1, 0, 1, 1, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0010, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0010, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000);

      foreach (tv[i]) begin
         rst = tv[i].rst; a = tv[i].a; cfg_mode = tv[i].mode;
         out_ready = tv[i].rdy; clr_overflow = tv[i].clr;
         step();
         chk("out_valid", i, int'(out_valid), int'(tv[i].ev));
         chk("pending", i, int'(pending), int'(tv[i].ep));
         chk("overflow", i, int'(overflow), int'(tv[i].eo));
         if (tv[i].ev || tv[i].rst) chk("out_id", i, int'(out_id), int'(tv[i].eid));
      end

      // hand sequence: held backpressure on a ch2 event, bounded wait for valid
      rst = 1'b1; a = '0; cfg_mode = '0; out_ready = 1'b0; clr_overflow = 1'b0;
      step();
      rst = 1'b0; a = 4'b0100;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk("bp_valid_seen", 100, int'(seen), 1);
      for (int c = 0; c < 4; c++) begin
         a = 4'b0000;
         step();
         chk("bp_hold_valid", 101 + c, int'(out_valid), 1);
         chk("bp_hold_id", 101 + c, int'(out_id), 2);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release_valid", 110, int'(out_valid), 0);
      chk("bp_release_pending", 110, int'(pending), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_edge_event_arbiter

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel event front-end: per-channel detection of rising edges or one-cycle (010) pulses on level inputs, each latched as a pending request. A round-robin arbiter serialises the pending requests into a single valid/ready event stream carrying the channel index. Sits between raw strobe/button-style inputs and a single downstream event consumer.

## Interface

- Synchronous, active-high reset `rst`, single clock `clk`.

Parameters:
- `N`, default 4: number of channels (2..16).
- `ID_W`, default `$clog2(N)`: width of the channel index.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `a` in N: level inputs, already synchronous to `clk`.
- `cfg_mode` in N: per-channel detect mode. 0 = rising edge (`~a_r & a`); 1 = one-cycle pulse 010 (`~a_r2 & a_r & ~a`). Static; changes only while `rst` is high.
- `out_valid` out 1: event available.
- `out_id` out `ID_W`: channel index of the event; meaningful only when `out_valid` is high.
- `out_ready` in 1: consumer accepts; handshake fires when `out_valid & out_ready`.
- `pending` out N: per-channel latched, not-yet-issued requests.
- `overflow` out N: sticky per-channel flag; an event was dropped.
- `clr_overflow` in 1: clears all `overflow` bits on the next edge.

## Operation

- Per-channel history registers `a_r` and `a_r2`, both 0 at reset. Detect strobe `det[i]` is combinational from the history registers per `cfg_mode[i]`.
- Pending update per channel, evaluated each edge:
  - `pending[i]` next = (`pending[i]` & ~`take[i]`) | `det[i]`.
  - `take[i]` is high when channel i is loaded into the output register this cycle.
- Overflow: if `det[i]` & `pending[i]` & ~`take[i]`, set `overflow[i]`. The new event merges into the existing pending bit and is not issued twice.
  - `det[i]` and `take[i]` in the same cycle: `pending[i]` stays 1, no overflow.
  - `clr_overflow` and a new overflow in the same cycle: the set wins.
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- A load is allowed when (EMPTY or handshake fires) and `|pending`.
  - Load: `out_id` is the first set bit of `pending`, scanning from `ptr` upward with wrap modulo N.
  - `ptr` becomes `out_id`+1 mod N.
  - `take[out_id]` is asserted.
- Handshake fires with `pending`=0: the register goes EMPTY.
- FULL and no handshake: `out_valid` and `out_id` hold stable (AXI-style; no retraction, no id change).
- Arbitration uses `pending` at the start of the cycle only. A same-cycle `det` is not eligible until the next cycle.

## Timing

- Reset values: `out_valid`=0, `out_id`=0, `pending`=0, `overflow`=0, `ptr`=0, all history registers 0.
- Rising mode: `a` goes high before edge k, so `det` is high in cycle k. `pending` is set after edge k, and `out_valid` rises after edge k+1 when the output register is free.
- Pulse mode: `det` is one cycle later than in rising mode, because the trailing 0 must be seen.
- Throughput: one event per cycle while `out_ready` is held high and requests are pending.
- `rst` asserted mid-operation: on the next edge all state returns to reset values. In-flight and pending events are discarded, and no `overflow` is recorded.
- An input already high when `rst` deasserts produces a rising event, because `a_r` is 0 after reset.

## Structure

- Package `edge_event_arbiter_pkg`:
  - `det_mode_e` enum with `DET_RISE`=0 and `DET_PULSE`=1.
  - Default `N` constant.
- Sub-module `event_detector`: one channel's history registers plus the mode mux, outputting `det`. It is instantiated N times in a generate loop.
- The round-robin scan, pending, overflow and output register live in the top level.

## Test plan

- Rising, N=4, `out_ready`=1: `a[2]` 0→1 and held high → exactly one event with `out_id`=2, `out_valid` high two cycles after the edge, `pending` back to 0.
- Pulse mode on ch1: `a[1]`=0,1,0 → one event with id 1. Pattern 0,1,1,0 on ch1 → no event.
- Round-robin: all four channels rise in the same cycle, `out_ready`=1 → ids 0,1,2,3 on consecutive cycles. A repeat after `ptr`=1 grants 1,2,3,0.
- Backpressure and overflow: `out_ready`=0 and ch0 rises twice (rise, fall, rise) → one pending event. `overflow[0]`=1 if the second rise arrives while ch0 is still pending. `out_id` stays stable until `out_ready`=1. `clr_overflow` then clears the flag.
- Simultaneous take and detect: ch3 is loaded into the output in the same cycle a new ch3 edge is detected → `pending[3]` stays 1, `overflow[3]`=0, and a second event with id 3 follows.
- Reset mid-stream: `rst` pulsed while `out_valid`=1 and `pending`=4'b1010 → all outputs 0 on the next cycle, and no events emerge afterwards without new edges.
